vic_cpu_if: RTL and testbench

CPU-side endpoint of the VICtor vectored interrupt handshake. It captures the request pulse and 5-bit vector number issued by the interrupt controller and waits for an interruptible instruction boundary. It then fetches the handler address from the vector table, redirects the pipeline and holds the in-service line high until return-from-interrupt. It sits between the interrupt controller and the CPU fetch/control logic.

---
 rtl/vic_cpu_if_if.sv | 39 +++
 rtl/vic_cpu_if.sv | 109 ++++++++++
 tb/tb_vic_cpu_if.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vic_cpu_if_if.sv
// CPU-side VICtor handshake bundle: controller request lines,
// CPU boundary/PC inputs, vector-table read port and redirect.
interface vic_cpu_if_if #(
  parameter int ADDR_W = 32
);
  logic              i_irq_req;
  logic [4:0]        i_irq_num;
  logic              o_in_service;
  logic              i_gie;
  logic              i_boundary;
  logic [ADDR_W-1:0] i_pc;
  logic              o_stall;
  logic              o_mem_req;
  logic [ADDR_W-1:0] o_mem_addr;
  logic              i_mem_ack;
  logic [ADDR_W-1:0] i_mem_rdata;
  logic              o_redirect;
  logic [ADDR_W-1:0] o_redirect_pc;
  logic              i_reti;
  logic [ADDR_W-1:0] o_epc;
  logic [4:0]        o_active_num;
  logic              o_overrun;

  modport slave (
    input  i_irq_req, i_irq_num, i_gie, i_boundary, i_pc,
    input  i_mem_ack, i_mem_rdata, i_reti,
    output o_in_service, o_stall, o_mem_req, o_mem_addr,
    output o_redirect, o_redirect_pc, o_epc, o_active_num,
    output o_overrun
  );

  modport master (
    output i_irq_req, i_irq_num, i_gie, i_boundary, i_pc,
    output i_mem_ack, i_mem_rdata, i_reti,
    input  o_in_service, o_stall, o_mem_req, o_mem_addr,
    input  o_redirect, o_redirect_pc, o_epc, o_active_num,
    input  o_overrun
  );
endinterface

// File: rtl/vic_cpu_if.sv
// VICtor CPU endpoint: latches a vectored request, waits for a
// boundary, fetches the handler address and redirects the CPU.
module vic_cpu_if #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] VEC_BASE = 32'h0000_0080
) (
  input logic         i_clk,
  input logic         i_rst,
  vic_cpu_if_if.slave bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] PEND    = 3'd1;
  localparam logic [2:0] FETCH   = 3'd2;
  localparam logic [2:0] JUMP    = 3'd3;
  localparam logic [2:0] SERVICE = 3'd4;
  localparam logic [2:0] RETURN  = 3'd5;

  logic [2:0]        state;
  logic              req_s;
  logic              req_q;
  logic [4:0]        num_s;
  logic [4:0]        pend_num;
  logic              req_edge;
  logic [4:0]        take_num;
  logic [ADDR_W-1:0] take_addr;
  logic              busy;

  // Request and number are registered together so the edge
  // always pairs with the number from the first high cycle.
  assign req_edge  = req_s & ~req_q;
  assign take_num  = req_edge ? num_s : pend_num;
  assign take_addr = VEC_BASE
                   + {{(ADDR_W-7){1'b0}}, take_num, 2'b00};
  assign busy      = (state == FETCH) || (state == JUMP)
                   || (state == SERVICE) || (state == RETURN);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state             <= IDLE;
      req_s             <= 1'b0;
      req_q             <= 1'b0;
      num_s             <= '0;
      pend_num          <= '0;
      bus.o_in_service  <= 1'b0;
      bus.o_stall       <= 1'b0;
      bus.o_mem_req     <= 1'b0;
      bus.o_mem_addr    <= '0;
      bus.o_redirect    <= 1'b0;
      bus.o_redirect_pc <= '0;
      bus.o_epc         <= '0;
      bus.o_active_num  <= '0;
      bus.o_overrun     <= 1'b0;
    end else begin
      req_s <= bus.i_irq_req;
      req_q <= req_s;
      num_s <= bus.i_irq_num;
      if (req_edge && busy) bus.o_overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (req_edge) begin
            pend_num <= num_s;
            state    <= PEND;
          end
        end
        PEND: begin
          if (req_edge) pend_num <= num_s;
          if (bus.i_boundary && bus.i_gie) begin
            bus.o_epc        <= bus.i_pc;
            bus.o_active_num <= take_num;
            bus.o_in_service <= 1'b1;
            bus.o_stall      <= 1'b1;
            bus.o_mem_req    <= 1'b1;
            bus.o_mem_addr   <= take_addr;
            state            <= FETCH;
          end
        end
        FETCH: begin
          if (bus.i_mem_ack) begin
            bus.o_mem_req     <= 1'b0;
            bus.o_stall       <= 1'b0;
            bus.o_redirect    <= 1'b1;
            bus.o_redirect_pc <=
              {bus.i_mem_rdata[ADDR_W-1:2], 2'b00};
            state             <= JUMP;
          end
        end
        JUMP: begin
          bus.o_redirect <= 1'b0;
          state          <= SERVICE;
        end
        SERVICE: begin
          if (bus.i_reti) begin
            bus.o_redirect    <= 1'b1;
            bus.o_redirect_pc <= bus.o_epc;
            state             <= RETURN;
          end
        end
        RETURN: begin
          bus.o_redirect   <= 1'b0;
          bus.o_in_service <= 1'b0;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vic_cpu_if.sv
// Directed bench for vic_cpu_if: default and wrapping vector
// bases, gating, overwrite, wait states, overrun and reset.
module tb_vic_cpu_if;

  logic        clk = 1'b0;
  logic        rst0 = 1'b1;
  logic        rst1 = 1'b1;
  logic        ack0 = 1'b0;
  logic        ack1 = 1'b0;
  logic [31:0] rdata0 = '0;
  logic [31:0] rdata1 = '0;
  int          tests = 0;
  int          fails = 0;

  vic_cpu_if_if #(.ADDR_W(32)) b0 ();
  vic_cpu_if_if #(.ADDR_W(32)) b1 ();

  assign b0.i_mem_ack   = b0.o_mem_req & ack0;
  assign b0.i_mem_rdata = rdata0;
  assign b1.i_mem_ack   = b1.o_mem_req & ack1;
  assign b1.i_mem_rdata = rdata1;

  vic_cpu_if #(
    .ADDR_W(32), .VEC_BASE(32'h0000_0080)
  ) u0 (.i_clk(clk), .i_rst(rst0), .bus(b0));

  vic_cpu_if #(
    .ADDR_W(32), .VEC_BASE(32'hFFFF_FFF0)
  ) u1 (.i_clk(clk), .i_rst(rst1), .bus(b1));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse0(input logic [4:0] n);
    b0.i_irq_num = n;
    b0.i_irq_req = 1'b1;
    tick();
    b0.i_irq_req = 1'b0;
  endtask

  task automatic service_done0();
    tick();
    tick();
    b0.i_reti = 1'b1;
    tick();
    b0.i_reti = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    b0.i_irq_req = 0; b0.i_irq_num = 0; b0.i_gie = 0;
    b0.i_boundary = 0; b0.i_pc = 0; b0.i_reti = 0;
    b1.i_irq_req = 0; b1.i_irq_num = 0; b1.i_gie = 0;
    b1.i_boundary = 0; b1.i_pc = 0; b1.i_reti = 0;
    tick();
    tick();
    tests++;
    if (b0.o_in_service !== 1'b0 || b0.o_stall !== 1'b0
        || b0.o_mem_req !== 1'b0 || b0.o_redirect !== 1'b0
        || b0.o_overrun !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags got %b%b%b%b%b exp 00000",
        b0.o_in_service, b0.o_stall, b0.o_mem_req,
        b0.o_redirect, b0.o_overrun);
    end
    tests++;
    if (b0.o_mem_addr !== 32'h0 || b0.o_epc !== 32'h0
        || b0.o_redirect_pc !== 32'h0
        || b0.o_active_num !== 5'd0) begin
      fails++;
      $display("FAIL reset_regs got %h %h %h %h exp zeros",
        b0.o_mem_addr, b0.o_epc, b0.o_redirect_pc,
        b0.o_active_num);
    end
    rst0 = 1'b0;
    rst1 = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    b0.i_gie = 1; b0.i_boundary = 1; b0.i_pc = 32'h1000;
    rdata0 = 32'h2003; ack0 = 1;
    pulse0(5'd5);
    tick();
    tick();
    b0.i_pc = 32'h1234;
    tests++;
    if (b0.o_mem_req !== 1'b1 || b0.o_mem_addr !== 32'h94) begin
      fails++;
      $display("FAIL basic_fetch got req=%b addr=%h exp 1 94",
        b0.o_mem_req, b0.o_mem_addr);
    end
    tests++;
    if (b0.o_in_service !== 1'b1 || b0.o_stall !== 1'b1
        || b0.o_epc !== 32'h1000) begin
      fails++;
      $display("FAIL basic_accept got ins=%b stall=%b epc=%h",
        b0.o_in_service, b0.o_stall, b0.o_epc);
    end
    tick();
    tests++;
    if (b0.o_redirect !== 1'b1 || b0.o_redirect_pc !== 32'h2000
        || b0.o_stall !== 1'b0) begin
      fails++;
      $display("FAIL basic_jump got r=%b pc=%h st=%b exp 1 2000 0",
        b0.o_redirect, b0.o_redirect_pc, b0.o_stall);
    end
    tick();
    tests++;
    if (b0.o_redirect !== 1'b0 || b0.o_in_service !== 1'b1) begin
      fails++;
      $display("FAIL basic_service got r=%b ins=%b exp 0 1",
        b0.o_redirect, b0.o_in_service);
    end
    b0.i_reti = 1;
    tick();
    b0.i_reti = 0;
    tests++;
    if (b0.o_redirect !== 1'b1 || b0.o_redirect_pc !== 32'h1000
        || b0.o_in_service !== 1'b1) begin
      fails++;
      $display("FAIL basic_return got r=%b pc=%h ins=%b",
        b0.o_redirect, b0.o_redirect_pc, b0.o_in_service);
    end
    tick();
    tests++;
    if (b0.o_in_service !== 1'b0 || b0.o_redirect !== 1'b0) begin
      fails++;
      $display("FAIL basic_idle got ins=%b r=%b exp 0 0",
        b0.o_in_service, b0.o_redirect);
    end
  endtask

  task automatic test_gated();
    b0.i_gie = 0;
    pulse0(5'd2);
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++;
      if (b0.o_in_service !== 1'b0 || b0.o_mem_req !== 1'b0) begin
        fails++;
        $display("FAIL gated_hold cyc %0d got ins=%b req=%b", i,
          b0.o_in_service, b0.o_mem_req);
      end
    end
    b0.i_gie = 1;
    tick();
    tests++;
    if (b0.o_in_service !== 1'b1 || b0.o_mem_req !== 1'b1
        || b0.o_mem_addr !== 32'h88) begin
      fails++;
      $display("FAIL gated_release got ins=%b req=%b addr=%h",
        b0.o_in_service, b0.o_mem_req, b0.o_mem_addr);
    end
    service_done0();
  endtask

  task automatic test_overwrite();
    b0.i_boundary = 0;
    pulse0(5'd3);
    tick();
    tick();
    pulse0(5'd17);
    tick();
    tick();
    b0.i_boundary = 1;
    tick();
    tests++;
    if (b0.o_mem_addr !== 32'hC4 || b0.o_active_num !== 5'd17) begin
      fails++;
      $display("FAIL overwrite got addr=%h num=%0d exp c4 17",
        b0.o_mem_addr, b0.o_active_num);
    end
    service_done0();
  endtask

  task automatic test_wait_overrun();
    ack0 = 0;
    rdata0 = 32'h3457;
    pulse0(5'd1);
    tick();
    tick();
    tests++;
    if (b0.o_overrun !== 1'b0) begin
      fails++;
      $display("FAIL overrun_pre got %b exp 0", b0.o_overrun);
    end
    for (int i = 0; i < 7; i++) begin
      if (i == 2) begin
        b0.i_irq_num = 5'd9;
        b0.i_irq_req = 1;
      end
      if (i == 3) b0.i_irq_req = 0;
      tick();
      tests++;
      if (b0.o_mem_req !== 1'b1 || b0.o_mem_addr !== 32'h84) begin
        fails++;
        $display("FAIL wait_stable cyc %0d got req=%b addr=%h",
          i, b0.o_mem_req, b0.o_mem_addr);
      end
    end
    tests++;
    if (b0.o_overrun !== 1'b1 || b0.o_active_num !== 5'd1) begin
      fails++;
      $display("FAIL overrun_post got ov=%b num=%0d exp 1 1",
        b0.o_overrun, b0.o_active_num);
    end
    ack0 = 1;
    tick();
    tests++;
    if (b0.o_redirect !== 1'b1 || b0.o_redirect_pc !== 32'h3454
        || b0.o_mem_req !== 1'b0) begin
      fails++;
      $display("FAIL wait_jump got r=%b pc=%h req=%b",
        b0.o_redirect, b0.o_redirect_pc, b0.o_mem_req);
    end
    service_done0();
  endtask

  task automatic test_wrap_reset();
    b1.i_gie = 1; b1.i_boundary = 1; b1.i_pc = 32'h400;
    ack1 = 0;
    b1.i_irq_num = 5'd31;
    b1.i_irq_req = 1;
    tick();
    b1.i_irq_req = 0;
    tick();
    tick();
    tests++;
    if (b1.o_mem_req !== 1'b1 || b1.o_mem_addr !== 32'h6C) begin
      fails++;
      $display("FAIL wrap_addr got req=%b addr=%h exp 1 6c",
        b1.o_mem_req, b1.o_mem_addr);
    end
    #2 rst1 = 1;
    #1;
    tests++;
    if (b1.o_mem_req !== 1'b0 || b1.o_in_service !== 1'b0
        || b1.o_stall !== 1'b0 || b1.o_redirect !== 1'b0
        || b1.o_overrun !== 1'b0) begin
      fails++;
      $display("FAIL async_rst_flags got %b%b%b%b%b exp 00000",
        b1.o_mem_req, b1.o_in_service, b1.o_stall,
        b1.o_redirect, b1.o_overrun);
    end
    tests++;
    if (b1.o_mem_addr !== 32'h0 || b1.o_epc !== 32'h0
        || b1.o_active_num !== 5'd0
        || b1.o_redirect_pc !== 32'h0) begin
      fails++;
      $display("FAIL async_rst_regs got %h %h %h %h exp zeros",
        b1.o_mem_addr, b1.o_epc, b1.o_active_num,
        b1.o_redirect_pc);
    end
    tick();
    rst1 = 0;
    ack1 = 1;
    rdata1 = 32'h5000;
    b1.i_irq_num = 5'd6;
    b1.i_irq_req = 1;
    tick();
    b1.i_irq_req = 0;
    tick();
    tick();
    tests++;
    if (b1.o_mem_addr !== 32'h08 || b1.o_active_num !== 5'd6) begin
      fails++;
      $display("FAIL post_rst_addr got addr=%h num=%0d exp 08 6",
        b1.o_mem_addr, b1.o_active_num);
    end
    tick();
    tests++;
    if (b1.o_redirect !== 1'b1 || b1.o_redirect_pc !== 32'h5000) begin
      fails++;
      $display("FAIL post_rst_jump got r=%b pc=%h exp 1 5000",
        b1.o_redirect, b1.o_redirect_pc);
    end
    tick();
    b1.i_irq_num = 5'd0;
    b1.i_irq_req = 1;
    tick();
    b1.i_irq_req = 0;
    b1.i_reti = 1;
    tick();
    b1.i_reti = 0;
    tests++;
    if (b1.o_redirect !== 1'b1 || b1.o_redirect_pc !== 32'h400
        || b1.o_overrun !== 1'b1) begin
      fails++;
      $display("FAIL reti_and_req got r=%b pc=%h ov=%b exp 1 400 1",
        b1.o_redirect, b1.o_redirect_pc, b1.o_overrun);
    end
    tick();
    tests++;
    if (b1.o_in_service !== 1'b0) begin
      fails++;
      $display("FAIL reti_and_req_idle got ins=%b exp 0",
        b1.o_in_service);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gated();
    test_overwrite();
    test_wait_overrun();
    test_wrap_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
